// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the alu_ctrl encodings the controller decodes, the sequencer FSM
// state type, the default register address width and the branch-decode helper.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [3:0] ALU_NOP  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1011;
    localparam logic [3:0] ALU_BNE  = 4'b1100;
    localparam logic [3:0] ALU_BEQZ = 4'b1101;
    localparam logic [3:0] ALU_BNEZ = 4'b1110;
    localparam logic [3:0] ALU_JUMP = 4'b1111;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_LU_BUBBLE = 2'd2
    } hz_state_e;

    // Jumps always redirect; conditional branches redirect only when taken.
    function automatic logic is_redirect(input logic [3:0] alu_ctrl, input logic cond_true);
        case (alu_ctrl)
            ALU_JUMP:                             return 1'b1;
            ALU_BEQ, ALU_BNE, ALU_BEQZ, ALU_BNEZ: return cond_true;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives stage info, receives enables/flushes/counters).
// slave:  controller side (pipe_hazard_ctrl).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = pipe_pkg::REG_AW,
    parameter int unsigned CNT_W  = 16
);

    // Stage information towards the controller
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_uses_rs2;
    logic [3:0]        ex_alu_ctrl;
    logic              ex_mem_rd;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_cond_true;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_ready;

    // Pipeline control and status from the controller
    logic              pc_en;
    logic              pc_sel_target;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_flush;
    logic              exmem_en;
    logic              memwb_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              wdog_err;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs2, ex_alu_ctrl, ex_mem_rd,
               ex_rd_addr, ex_cond_true, imem_ready, dmem_req, dmem_ready,
        input  pc_en, pc_sel_target, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_bubble, stall_cnt, flush_cnt, wdog_err
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs2, ex_alu_ctrl, ex_mem_rd,
               ex_rd_addr, ex_cond_true, imem_ready, dmem_req, dmem_ready,
        output pc_en, pc_sel_target, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_bubble, stall_cnt, flush_cnt, wdog_err
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async active-high), inc_i (count enable),
//        clr_i (clear, wins over inc_i), cnt_o (current count).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Hold at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline. Resolves dmem wait states,
// EX-stage redirects, load-use interlocks and imem wait states (in that
// priority) into pipeline-register enables/flushes and the PC source select.
// Keeps saturating stall/redirect counters and a sticky dmem watchdog.
// Ports: clk, rst (async active-high),
//        hz (slave): stage info in; enables, flushes, pc_sel_target,
//        stall_cnt, flush_cnt, wdog_err out.
// Control outputs are combinational from state and inputs; counters and
// wdog_err are registered.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned REG_AW   = pipe_pkg::REG_AW
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    import pipe_pkg::*;

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_e state_q;
    hz_state_e state_d;

    logic dmem_stall;
    logic redirect;
    logic load_use;

    logic pc_en_c;
    logic pc_sel_target_c;
    logic ifid_en_c;
    logic ifid_flush_c;
    logic idex_en_c;
    logic idex_flush_c;
    logic exmem_en_c;
    logic memwb_bubble_c;
    logic flush_inc_c;

    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wdog_q;
    logic              wdog_d;

    // Hazard classification
    always_comb begin
        dmem_stall = hz.dmem_req & ~hz.dmem_ready;
        redirect   = is_redirect(hz.ex_alu_ctrl, hz.ex_cond_true);
        load_use   = hz.ex_mem_rd && (hz.ex_rd_addr != '0) &&
                     ((hz.ex_rd_addr == hz.id_rs1_addr) ||
                      (hz.id_uses_rs2 && (hz.ex_rd_addr == hz.id_rs2_addr)));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline controls
    always_comb begin
        state_d         = state_q;
        pc_en_c         = 1'b1;
        pc_sel_target_c = 1'b0;
        ifid_en_c       = 1'b1;
        ifid_flush_c    = 1'b0;
        idex_en_c       = 1'b1;
        idex_flush_c    = 1'b0;
        exmem_en_c      = 1'b1;
        memwb_bubble_c  = 1'b0;
        flush_inc_c     = 1'b0;

        if (rst) begin
            state_d        = ST_RUN;
            pc_en_c        = 1'b0;
            ifid_en_c      = 1'b0;
            ifid_flush_c   = 1'b1;
            idex_en_c      = 1'b0;
            idex_flush_c   = 1'b1;
            exmem_en_c     = 1'b0;
            memwb_bubble_c = 1'b1;
        end else if (dmem_stall) begin
            // Freeze everything up to MEM; redirect/load-use wait for release
            state_d        = ST_DMEM_WAIT;
            pc_en_c        = 1'b0;
            ifid_en_c      = 1'b0;
            idex_en_c      = 1'b0;
            exmem_en_c     = 1'b0;
            memwb_bubble_c = 1'b1;
        end else if (redirect) begin
            // Flushing ID also squashes any load-use dependent, so no bubble
            state_d         = ST_RUN;
            pc_sel_target_c = 1'b1;
            ifid_flush_c    = 1'b1;
            idex_flush_c    = 1'b1;
            flush_inc_c     = 1'b1;
        end else if (load_use && (state_q != ST_LU_BUBBLE)) begin
            // EX holds the bubble next cycle, so the hazard is not re-detected there
            state_d      = ST_LU_BUBBLE;
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
        end else begin
            state_d = ST_RUN;
            if (!hz.imem_ready) begin
                pc_en_c      = 1'b0;
                ifid_flush_c = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (~pc_en_c | ~exmem_en_c),
        .clr_i (1'b0),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc_c),
        .clr_i (1'b0),
        .cnt_o (flush_cnt)
    );

    // Counts consecutive dmem stall cycles; any non-stalled cycle restarts it
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (dmem_stall),
        .clr_i (~dmem_stall),
        .cnt_o (wait_cnt)
    );

    // Sticky timeout, set on the edge that completes the MAX_WAIT-th wait cycle
    always_comb begin
        wdog_d = wdog_q | (dmem_stall & (wait_cnt >= WAIT_W'(MAX_WAIT - 1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign hz.pc_en         = pc_en_c;
    assign hz.pc_sel_target = pc_sel_target_c;
    assign hz.ifid_en       = ifid_en_c;
    assign hz.ifid_flush    = ifid_flush_c;
    assign hz.idex_en       = idex_en_c;
    assign hz.idex_flush    = idex_flush_c;
    assign hz.exmem_en      = exmem_en_c;
    assign hz.memwb_bubble  = memwb_bubble_c;
    assign hz.stall_cnt     = stall_cnt;
    assign hz.flush_cnt     = flush_cnt;
    assign hz.wdog_err      = wdog_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    import pipe_pkg::*;

    localparam int unsigned CW   = 8;
    localparam int unsigned MW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    // Output pattern {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
    localparam logic [7:0] P_RUN  = 8'b1010_1010;
    localparam logic [7:0] P_LU   = 8'b0000_1110;
    localparam logic [7:0] P_RED  = 8'b1111_1110;
    localparam logic [7:0] P_IMEM = 8'b0011_1010;
    localparam logic [7:0] P_DMEM = 8'b0000_0001;
    localparam logic [7:0] P_RST  = 8'b0001_0101;

    localparam int A_ADD = 0;
    localparam int A_OR  = 10;
    localparam int A_BEQ = 11;
    localparam int A_BNE = 12;
    localparam int A_BNZ = 14;
    localparam int A_JMP = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.CNT_W(CW), .MAX_WAIT(MW), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic [3:0] alu;
        logic       mem_rd;
        logic [4:0] rd;
        logic       cond;
        logic       imem_rdy;
        logic       dreq;
        logic       drdy;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int unsigned m_stall;
    int unsigned m_flush;
    int unsigned m_wait;
    bit          m_bubble;
    bit          m_wdog;

    function automatic stim_t mk(input int rs1, input int rs2, input int ub, input int alu,
                                 input int mr, input int rd, input int c, input int im,
                                 input int dq, input int dr);
        stim_t s;
        s.rs1      = 5'(rs1);
        s.rs2      = 5'(rs2);
        s.uses_rs2 = 1'(ub);
        s.alu      = 4'(alu);
        s.mem_rd   = 1'(mr);
        s.rd       = 5'(rd);
        s.cond     = 1'(c);
        s.imem_rdy = 1'(im);
        s.dreq     = 1'(dq);
        s.drdy     = 1'(dr);
        return s;
    endfunction

    // Expected controls from the hazard rules, highest priority first
    function automatic logic [7:0] model_out(input stim_t s, input bit in_rst);
        bit taken;
        bit hazard;
        if (in_rst) return P_RST;
        if (s.dreq && !s.drdy) return P_DMEM;
        taken = (s.alu == ALU_JUMP) ||
                (s.cond && (s.alu inside {ALU_BEQ, ALU_BNE, ALU_BEQZ, ALU_BNEZ}));
        if (taken) return P_RED;
        hazard = s.mem_rd && (s.rd != 5'd0) &&
                 ((s.rd == s.rs1) || (s.uses_rs2 && (s.rd == s.rs2)));
        if (hazard && !m_bubble) return P_LU;
        if (!s.imem_rdy) return P_IMEM;
        return P_RUN;
    endfunction

    function automatic void model_reset();
        m_stall  = 0;
        m_flush  = 0;
        m_wait   = 0;
        m_bubble = 1'b0;
        m_wdog   = 1'b0;
    endfunction

    function automatic void model_clock(input stim_t s, input bit in_rst);
        logic [7:0] o;
        if (in_rst) begin
            model_reset();
            return;
        end
        o = model_out(s, 1'b0);
        if ((!o[7] || !o[1]) && m_stall < CMAX) m_stall++;
        if (o == P_RED && m_flush < CMAX) m_flush++;
        if (o == P_DMEM) begin
            m_wait++;
            if (m_wait >= MW) m_wdog = 1'b1;
        end else begin
            m_wait = 0;
        end
        m_bubble = (o == P_LU);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic apply(input stim_t s);
        hz.id_rs1_addr  = s.rs1;
        hz.id_rs2_addr  = s.rs2;
        hz.id_uses_rs2  = s.uses_rs2;
        hz.ex_alu_ctrl  = s.alu;
        hz.ex_mem_rd    = s.mem_rd;
        hz.ex_rd_addr   = s.rd;
        hz.ex_cond_true = s.cond;
        hz.imem_ready   = s.imem_rdy;
        hz.dmem_req     = s.dreq;
        hz.dmem_ready   = s.drdy;
    endtask

    function automatic logic [7:0] outs();
        return {hz.pc_en, hz.pc_sel_target, hz.ifid_en, hz.ifid_flush,
                hz.idex_en, hz.idex_flush, hz.exmem_en, hz.memwb_bubble};
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "/stall_cnt"}, 32'(hz.stall_cnt), 32'(m_stall));
        chk({tag, "/flush_cnt"}, 32'(hz.flush_cnt), 32'(m_flush));
        chk({tag, "/wdog_err"},  32'(hz.wdog_err),  32'(m_wdog));
    endtask

    // One clock: drive at negedge, check mid-cycle, then advance the model at posedge
    task automatic run_cycle(input stim_t s, input bit r, input string tag,
                             input bit use_tab, input logic [7:0] tab_exp);
        @(negedge clk);
        rst = r;
        apply(s);
        if (r) model_reset();
        #1;
        chk({tag, "/outs"}, 32'(outs()), 32'(model_out(s, r)));
        if (use_tab) chk({tag, "/table"}, 32'(outs()), 32'(tab_exp));
        chk_state(tag);
        @(posedge clk);
        model_clock(s, r);
    endtask

    vec_t  tab[19];
    stim_t idle;
    stim_t st;
    stim_t sv;

    initial begin
        idle = mk(1, 2, 0, A_ADD, 0, 0, 0, 1, 0, 0);
        rst  = 1'b1;
        apply(idle);
        model_reset();

        tab[0]  = '{mk(1, 2, 0, A_ADD, 0, 0, 0, 1, 0, 0), P_RUN};
        tab[1]  = '{mk(3, 4, 0, A_ADD, 1, 3, 0, 1, 0, 0), P_LU};
        tab[2]  = '{mk(3, 4, 0, A_ADD, 1, 3, 0, 1, 0, 0), P_RUN};
        tab[3]  = '{mk(0, 4, 0, A_ADD, 1, 0, 0, 1, 0, 0), P_RUN};
        tab[4]  = '{mk(1, 7, 1, A_ADD, 1, 7, 0, 1, 0, 0), P_LU};
        tab[5]  = '{mk(1, 2, 0, A_ADD, 0, 0, 0, 1, 0, 0), P_RUN};
        tab[6]  = '{mk(1, 7, 0, A_ADD, 1, 7, 0, 1, 0, 0), P_RUN};
        tab[7]  = '{mk(1, 2, 0, A_BEQ, 0, 0, 1, 1, 0, 0), P_RED};
        tab[8]  = '{mk(1, 2, 0, A_BEQ, 0, 0, 0, 1, 0, 0), P_RUN};
        tab[9]  = '{mk(1, 2, 0, A_JMP, 0, 0, 0, 1, 0, 0), P_RED};
        tab[10] = '{mk(1, 2, 0, A_BNZ, 0, 0, 1, 1, 0, 0), P_RED};
        tab[11] = '{mk(1, 2, 0, A_OR,  0, 0, 1, 1, 0, 0), P_RUN};
        tab[12] = '{mk(1, 2, 0, A_ADD, 0, 0, 0, 0, 0, 0), P_IMEM};
        tab[13] = '{mk(3, 4, 0, A_JMP, 1, 3, 0, 1, 0, 0), P_RED};
        tab[14] = '{mk(3, 4, 0, A_ADD, 1, 3, 0, 1, 0, 0), P_LU};
        tab[15] = '{mk(1, 2, 0, A_BNE, 0, 0, 1, 1, 1, 0), P_DMEM};
        tab[16] = '{mk(1, 2, 0, A_BNE, 0, 0, 1, 1, 1, 1), P_RED};
        tab[17] = '{mk(3, 4, 0, A_ADD, 1, 3, 0, 0, 0, 0), P_LU};
        tab[18] = '{mk(1, 2, 0, A_ADD, 0, 0, 0, 0, 0, 0), P_IMEM};

        // Reset state
        run_cycle(idle, 1'b1, "reset", 1'b1, P_RST);
        run_cycle(idle, 1'b1, "reset_hold", 1'b1, P_RST);

        // Single-cycle vectors applied back to back
        foreach (tab[i]) run_cycle(tab[i].s, 1'b0, $sformatf("vec%0d", i), 1'b1, tab[i].exp);

        // Load-use stall counts exactly one cycle
        run_cycle(idle, 1'b1, "lu_rst", 1'b0, P_RST);
        run_cycle(mk(3, 4, 0, A_ADD, 1, 3, 0, 1, 0, 0), 1'b0, "lu_a", 1'b1, P_LU);
        run_cycle(mk(3, 4, 0, A_ADD, 1, 3, 0, 1, 0, 0), 1'b0, "lu_b", 1'b1, P_RUN);
        #1 chk("lu/stall_cnt", 32'(hz.stall_cnt), 32'd1);

        // Five dmem wait cycles hold off a taken BNE until the release cycle
        run_cycle(idle, 1'b1, "dm_rst", 1'b0, P_RST);
        st = mk(1, 2, 0, A_BNE, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) run_cycle(st, 1'b0, $sformatf("dm_wait%0d", i), 1'b1, P_DMEM);
        st.drdy = 1'b1;
        run_cycle(st, 1'b0, "dm_release", 1'b1, P_RED);
        #1;
        chk("dm/stall_cnt", 32'(hz.stall_cnt), 32'd5);
        chk("dm/flush_cnt", 32'(hz.flush_cnt), 32'd1);

        // Watchdog: set after MW wait cycles, sticky until reset
        run_cycle(idle, 1'b1, "wd_rst", 1'b0, P_RST);
        st = mk(1, 2, 0, A_ADD, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) run_cycle(st, 1'b0, "wd_wait", 1'b0, P_DMEM);
        #1 chk("wd/before_limit", 32'(hz.wdog_err), 32'd0);
        run_cycle(st, 1'b0, "wd_wait4", 1'b0, P_DMEM);
        #1 chk("wd/at_limit", 32'(hz.wdog_err), 32'd1);
        run_cycle(idle, 1'b0, "wd_idle0", 1'b1, P_RUN);
        run_cycle(idle, 1'b0, "wd_idle1", 1'b1, P_RUN);
        #1 chk("wd/sticky", 32'(hz.wdog_err), 32'd1);
        run_cycle(idle, 1'b1, "wd_clear", 1'b0, P_RST);
        #1 chk("wd/cleared", 32'(hz.wdog_err), 32'd0);

        // Asynchronous reset in the middle of a dmem wait
        run_cycle(idle, 1'b0, "ar_idle", 1'b1, P_RUN);
        st = mk(1, 2, 0, A_BEQ, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++) run_cycle(st, 1'b0, "ar_wait", 1'b1, P_DMEM);
        #1 chk("ar/stall_seven", 32'(hz.stall_cnt), 32'd7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("ar/outs", 32'(outs()), 32'(P_RST));
        chk("ar/stall_cnt", 32'(hz.stall_cnt), 32'd0);
        chk("ar/flush_cnt", 32'(hz.flush_cnt), 32'd0);
        chk("ar/wdog_err", 32'(hz.wdog_err), 32'd0);
        run_cycle(idle, 1'b1, "ar_hold", 1'b1, P_RST);
        run_cycle(idle, 1'b0, "ar_run", 1'b1, P_RUN);
        run_cycle(mk(3, 4, 0, A_ADD, 1, 3, 0, 1, 0, 0), 1'b0, "ar_lu", 1'b1, P_LU);

        // Stall counter saturation
        st = mk(1, 2, 0, A_ADD, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) run_cycle(st, 1'b0, "sat", 1'b1, P_IMEM);
        #1 chk("sat/stall_cnt", 32'(hz.stall_cnt), 32'(CMAX));

        // Random traffic against the model
        run_cycle(idle, 1'b1, "rnd_rst", 1'b0, P_RST);
        for (int i = 0; i < 3000; i++) begin
            int unsigned pick;
            sv.rs1      = 5'($urandom_range(0, 3));
            sv.rs2      = 5'($urandom_range(0, 3));
            sv.uses_rs2 = 1'($urandom_range(0, 1));
            sv.rd       = 5'($urandom_range(0, 3));
            sv.mem_rd   = 1'($urandom_range(0, 1));
            sv.cond     = 1'($urandom_range(0, 1));
            sv.imem_rdy = ($urandom_range(0, 3) != 0);
            sv.dreq     = ($urandom_range(0, 3) == 0);
            sv.drdy     = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 7);
            case (pick)
                0:       sv.alu = 4'(A_OR);
                1:       sv.alu = ALU_BEQ;
                2:       sv.alu = ALU_BNE;
                3:       sv.alu = ALU_BEQZ;
                4:       sv.alu = ALU_BNEZ;
                5:       sv.alu = ALU_JUMP;
                6:       sv.alu = ALU_NOP;
                default: sv.alu = 4'(A_ADD);
            endcase
            run_cycle(sv, ($urandom_range(0, 299) == 0), "rnd", 1'b0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
